uart_host_rx: RTL and testbench
===============================

Name: uart_host_rx

Overview:
- Serial receiver for the host/bench end of the CPU's UART link.
- Deserialises the frames the CPU drives on Tx into bytes and buffers them in a small show-ahead FIFO.
- Flags parity, framing and overflow errors.
- Used by sim benches and host-side logic to read program output from riscv_top.

Parameters:
SYS_CLK_FREQ, 100000000, clk frequency in Hz
BAUD_RATE, 115200, line rate in bit/s
DATA_BITS, 8, data bits per frame, LSB first (supported range 5..8)
PARITY_MODE, 1, 0 = none, 1 = even, 2 = odd
FIFO_ADDR_BITS, 3, FIFO depth = 2**FIFO_ADDR_BITS

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx  input  1  serial line, idle high, asynchronous to clk
rd_en  input  1  pop request; ignored when empty
rd_data  output  8  FIFO head byte; zero-extended when DATA_BITS < 8
empty  output  1  FIFO empty
count  output  FIFO_ADDR_BITS+1  bytes held
parity_err  output  1  sticky parity error
frame_err  output  1  sticky framing error
overflow  output  1  sticky overflow error
err_clr  input  1  clears all three sticky flags

Behaviour:
- Interface: one clock (clk); rst_n is asynchronous and active-low. All state resets immediately on rst_n low.
- Reset values:
  - Outputs: rd_data=0, empty=1, count=0, all error flags=0.
  - Internal: FSM=IDLE; synchroniser loaded with 1s.
- rx passes through a 2-FF synchroniser; all sampling uses the synchronised value rx_s.
- Oversample tick:
  - DIV = SYS_CLK_FREQ/(BAUD_RATE*16), integer-truncated, minimum 1.
  - A counter generates a one-cycle tick every DIV clks.
  - The counter restarts at 0 when IDLE detects a start edge.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: rx_s 1->0 -> START, tick count=0.
  - START: at tick 8 (mid-bit), rx_s=0 -> DATA; rx_s=1 -> IDLE (glitch, no flag).
  - DATA: sample every 16 ticks and shift in LSB first. After DATA_BITS samples -> PARITY, or -> STOP when PARITY_MODE=0.
  - PARITY: sample after 16 ticks. Expected parity bit = XOR(data) for even, ~XOR(data) for odd. Mismatch marks the byte bad.
  - STOP: sample after 16 ticks.
    - rx_s=1 and byte good -> push, -> IDLE.
    - rx_s=1 and parity bad -> discard, parity_err<=1, -> IDLE.
    - rx_s=0 -> discard, frame_err<=1, -> WAIT_IDLE.
  - WAIT_IDLE: remain until rx_s=1, then -> IDLE. This prevents a break or held-low line from retriggering starts.
- Receiving resumes in IDLE immediately after the stop mid-sample, so back-to-back frames are accepted.
- FIFO:
  - Circular buffer with separate rd/wr pointers.
  - count changes by +1 on push only, -1 on pop only, 0 on both.
  - rd_data always shows the head: show-ahead, registered, updated the cycle after push or pop.
  - Pop when rd_en=1 and empty=0.
  - A push lands on the cycle of the stop sample. empty falls the following cycle, with rd_data valid in that same cycle.
  - Push while full and no pop -> byte dropped, overflow<=1, contents unchanged.
  - Push while full with simultaneous pop -> both occur; count stays at depth.
  - Pointers wrap modulo depth.
- Error flags are sticky until err_clr=1 (cleared next cycle). A set event coincident with err_clr wins: the flag stays 1.
- Reset mid-frame: the partial frame is lost and the FSM returns to IDLE. A frame still in progress on rx after reset deasserts may be misframed. This is acceptable; it is covered by WAIT_IDLE or frame_err.

Test Plan:
- PARITY_MODE=1, SYS_CLK_FREQ=1600, BAUD_RATE=100 (DIV=1, 16 clk/bit), for all scenarios.
- Send 0xA5 (parity bit 0, stop 1) -> empty falls 1 clk after the stop mid-sample; rd_data=0xA5; count=1. Pulse rd_en -> empty=1, count=0.
- rx low for 5 clks then high -> no push; no flags; FSM back in IDLE.
- Send 0x3C with parity bit 1 -> parity_err=1; empty stays 1. Pulse err_clr -> parity_err=0.
- Send 0x55 with stop bit 0, hold rx low 40 clks, then send 0x12 correctly -> frame_err=1; only 0x12 is in the FIFO.
- Send 0x01..0x09 back-to-back with no reads -> overflow=1; count=8; successive pops return 0x01..0x08, then empty=1.
- Assert rst_n low mid-DATA of 0x77, release, and wait for idle line before sending 0x42 -> rd_data=0x42, count=1, all flags 0.

Source files
------------

// File: rtl/uart_host_rx.sv
// rtl/uart_host_rx.sv - UART frame receiver with sticky error flags and show-ahead byte FIFO
`timescale 1ns/1ps
module uart_host_rx #(
    parameter int SYS_CLK_FREQ   = 100000000,
    parameter int BAUD_RATE      = 115200,
    parameter int DATA_BITS      = 8,
    parameter int PARITY_MODE    = 1,
    parameter int FIFO_ADDR_BITS = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx,
    input  logic                      rd_en,
    output logic [7:0]                rd_data,
    output logic                      empty,
    output logic [FIFO_ADDR_BITS:0]   count,
    output logic                      parity_err,
    output logic                      frame_err,
    output logic                      overflow,
    input  logic                      err_clr
);
    localparam int DIV_RAW = SYS_CLK_FREQ / (BAUD_RATE * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DEPTH   = 1 << FIFO_ADDR_BITS;
    localparam int CNT_W   = FIFO_ADDR_BITS + 1;
    localparam logic [CW-1:0]             DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0]             DIV_ONE   = CW'(1);
    localparam logic [2:0]                BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic [FIFO_ADDR_BITS-1:0] PTR_ONE   = FIFO_ADDR_BITS'(1);
    localparam logic [CNT_W-1:0]          CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]          CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic                      ODD_PAR   = (PARITY_MODE == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE} state_t;

    logic                      sync0_q, sync1_q, rx_prev_q;
    logic [CW-1:0]             div_cnt_q, div_cnt_d;
    state_t                    state_q, state_d;
    logic [3:0]                tick_cnt_q, tick_cnt_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic [7:0]                shift_q, shift_d;
    logic                      par_bad_q, par_bad_d;
    logic [7:0]                mem_q [DEPTH];
    logic [FIFO_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [7:0]                rd_data_q, rd_data_d;
    logic                      empty_q, empty_d;
    logic                      parity_err_q, parity_err_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overflow_q, overflow_d;

    logic       rx_s, tick, restart, push, set_par, set_frame;
    logic       do_pop, do_push, set_ovf, full;
    logic [7:0] push_data;

    assign rx_s      = sync1_q;
    assign tick      = (div_cnt_q == DIV_LAST);
    // Data arrives LSB first, so after DATA_BITS shifts it sits in the top bits of shift_q.
    assign push_data = shift_q >> (8 - DATA_BITS);

    // Oversample divider; realigned to the start edge so mid-bit samples are centred.
    always_comb begin
        div_cnt_d = div_cnt_q + DIV_ONE;
        if (restart || tick) div_cnt_d = '0;
    end

    // Frame FSM: bit timing from 16x ticks, parity check and stop-bit verdict.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_bad_d  = par_bad_q;
        restart    = 1'b0;
        push       = 1'b0;
        set_par    = 1'b0;
        set_frame  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    shift_d    = '0;
                    par_bad_d  = 1'b0;
                    restart    = 1'b1;
                end
            end
            S_START: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd7) begin
                        tick_cnt_d = '0;
                        state_d    = rx_s ? S_IDLE : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        shift_d   = {rx_s, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == BIT_LAST)
                            state_d = (PARITY_MODE == 0) ? S_STOP : S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        par_bad_d = (rx_s != ((^shift_q) ^ ODD_PAR));
                        state_d   = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        if (rx_s) begin
                            push    = !par_bad_q;
                            set_par = par_bad_q;
                            state_d = S_IDLE;
                        end else begin
                            set_frame = 1'b1;
                            state_d   = S_WAIT_IDLE;
                        end
                    end
                end
            end
            S_WAIT_IDLE: if (rx_s) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // FIFO bookkeeping and show-ahead head; a push landing at the new head is forwarded.
    always_comb begin
        full     = (count_q == CNT_DEPTH);
        do_pop   = rd_en && !empty_q;
        do_push  = push && (!full || do_pop);
        set_ovf  = push && full && !do_pop;
        wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) count_d = count_q + CNT_ONE;
        if (do_pop && !do_push) count_d = count_q - CNT_ONE;
        empty_d   = (count_d == '0);
        rd_data_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem_q[rd_ptr_d];
        // A set event in the same cycle as err_clr keeps the flag high.
        parity_err_d = set_par   || (parity_err_q && !err_clr);
        frame_err_d  = set_frame || (frame_err_q  && !err_clr);
        overflow_d   = set_ovf   || (overflow_q   && !err_clr);
    end

    // State registers; synchroniser preloads 1s so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q      <= 1'b1;
            sync1_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            div_cnt_q    <= '0;
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_data_q    <= '0;
            empty_q      <= 1'b1;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            sync0_q      <= rx;
            sync1_q      <= sync0_q;
            rx_prev_q    <= rx_s;
            div_cnt_q    <= div_cnt_d;
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rd_data_q    <= rd_data_d;
            empty_q      <= empty_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
            if (do_push) mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign rd_data    = rd_data_q;
    assign empty      = empty_q;
    assign count      = count_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_uart_host_rx.sv
// tb/tb_uart_host_rx.sv - self-checking bench for uart_host_rx
`timescale 1ns/1ps
module tb_uart_host_rx;
    logic       clk = 1'b0;
    logic       rst_n, rx, rd_en, err_clr;
    logic [7:0] rd_data;
    logic       empty, parity_err, frame_err, overflow;
    logic [3:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    uart_host_rx #(
        .SYS_CLK_FREQ(1600), .BAUD_RATE(100), .DATA_BITS(8),
        .PARITY_MODE(1), .FIFO_ADDR_BITS(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .rd_en(rd_en), .rd_data(rd_data),
        .empty(empty), .count(count), .parity_err(parity_err),
        .frame_err(frame_err), .overflow(overflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] data;
        logic       flip_par;
        logic       stop_val;
        logic       exp_push;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        clocks(16);
    endtask

    // Start bit, 8 data bits LSB first, even parity (optionally inverted), stop bit.
    task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop_val);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((^d) ^ flip);
        send_bit(stop_val);
        rx = 1'b1;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        clocks(1);
        rd_en = 1'b0;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        clocks(1);
        err_clr = 1'b0;
    endtask

    vec_t       vecs [6];
    logic [7:0] model_q [$];
    logic [7:0] d;
    logic       flip, any_flip;
    int         burst;

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0; rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        clocks(3);
        check("reset_empty", empty, 1);
        check("reset_count", count, 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_flags", {parity_err, frame_err, overflow}, 0);
        rst_n = 1'b1;
        clocks(20);

        // 0xA5 with latency: empty still high early in the stop bit, low by its end.
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(8'hA5 >> i);
        send_bit(1'b0);
        rx = 1'b1;
        clocks(4);
        check("a5_empty_before_mid", empty, 1);
        clocks(10);
        check("a5_empty_after_mid", empty, 0);
        check("a5_rd_data", rd_data, 8'hA5);
        check("a5_count", count, 1);
        clocks(2);
        pop();
        check("a5_pop_empty", empty, 1);
        check("a5_pop_count", count, 0);
        clocks(10);

        // Short glitch on the line must not produce a byte or a flag.
        rx = 1'b0; clocks(5); rx = 1'b1; clocks(40);
        check("glitch_empty", empty, 1);
        check("glitch_flags", {parity_err, frame_err, overflow}, 0);

        // Table of single frames.
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].data, vecs[v].flip_par, vecs[v].stop_val);
            clocks(20);
            check($sformatf("vec%0d_perr", v), parity_err, vecs[v].exp_perr);
            check($sformatf("vec%0d_ferr", v), frame_err, vecs[v].exp_ferr);
            check($sformatf("vec%0d_empty", v), empty, !vecs[v].exp_push);
            if (vecs[v].exp_push) begin
                check($sformatf("vec%0d_data", v), rd_data, vecs[v].data);
                pop();
            end
            clear_errs();
            check($sformatf("vec%0d_clr", v), {parity_err, frame_err, overflow}, 0);
            clocks(10);
        end

        // Bad parity then clear.
        send_frame(8'h3C, 1'b1, 1'b1);
        clocks(4);
        check("par_err_set", parity_err, 1);
        check("par_empty", empty, 1);
        clear_errs();
        check("par_err_clr", parity_err, 0);

        // Framing error followed by a held-low line, then a good frame.
        send_frame(8'h55, 1'b0, 1'b0);
        rx = 1'b0; clocks(40); rx = 1'b1; clocks(20);
        send_frame(8'h12, 1'b0, 1'b1);
        clocks(4);
        check("frm_err_set", frame_err, 1);
        check("frm_count", count, 1);
        check("frm_rd_data", rd_data, 8'h12);
        pop();
        check("frm_empty", empty, 1);
        clear_errs();

        // Nine back-to-back frames overflow an 8-deep FIFO.
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1);
        clocks(4);
        check("ovf_flag", overflow, 1);
        check("ovf_count", count, 8);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("ovf_pop%0d", i), rd_data, i);
            pop();
        end
        check("ovf_empty", empty, 1);
        clear_errs();
        check("ovf_clr", overflow, 0);

        // Random bursts against a queue model; flipped parity bytes are dropped.
        for (int b = 0; b < 6; b++) begin
            burst = $urandom_range(1, 3);
            any_flip = 1'b0;
            for (int k = 0; k < burst; k++) begin
                d = 8'($urandom);
                flip = ($urandom_range(0, 3) == 0);
                send_frame(d, flip, 1'b1);
                if (flip) any_flip = 1'b1;
                else model_q.push_back(d);
            end
            clocks(4);
            check($sformatf("rnd%0d_perr", b), parity_err, any_flip);
            check($sformatf("rnd%0d_count", b), count, model_q.size());
            while (model_q.size() > 0) begin
                check($sformatf("rnd%0d_data", b), rd_data, model_q.pop_front());
                pop();
            end
            check($sformatf("rnd%0d_empty", b), empty, 1);
            clear_errs();
            clocks(5);
        end

        // Reset mid-frame with stored data and a set flag.
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(8'h77 >> i);
        rst_n = 1'b0; rx = 1'b1;
        #1;
        check("rst_async_count", count, 0);
        check("rst_async_empty", empty, 1);
        check("rst_async_perr", parity_err, 0);
        clocks(3);
        rst_n = 1'b1;
        clocks(40);
        send_frame(8'h42, 1'b0, 1'b1);
        clocks(4);
        check("rst_rd_data", rd_data, 8'h42);
        check("rst_count", count, 1);
        check("rst_flags", {parity_err, frame_err, overflow}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
